// File: rtl/muxn_scan_pkg.sv
// Shared constants for the scanning N-to-1 multiplexer: mode encodings and a
// parameter legality helper used at elaboration.
package muxn_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Dwell must be at least 2 cycles and DWELL-1 must fit in the counter.
    function automatic bit dwell_legal(input int unsigned dwell, input int unsigned cnt_w);
        return (dwell >= 2) && (dwell <= 65535) && ((64'(dwell) - 1) < (64'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/muxn_scan_sel.sv
// Combinational channel slicer: picks channel i_sel out of the packed bus i_x.
module muxn_scan_sel
    import muxn_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input  logic [(2**SEL_W)*WIDTH-1:0] i_x,
    input  logic [SEL_W-1:0]            i_sel,
    output logic [WIDTH-1:0]            o_y
);

    assign o_y = i_x[i_sel*WIDTH +: WIDTH];

endmodule

// File: rtl/muxn_scan.sv
// Registered N-to-1 multiplexer with manual (strobed) or round-robin scan
// selection; y_valid drops for one cycle whenever the select moves.
module muxn_scan
    import muxn_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int DWELL = 4,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [(2**SEL_W)*WIDTH-1:0] x,
    input  logic [SEL_W-1:0]            c,
    input  logic                        load,
    input  logic                        mode,
    output logic [WIDTH-1:0]            y,
    output logic                        y_valid,
    output logic [SEL_W-1:0]            ch
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    generate
        if (!dwell_legal(DWELL, CNT_W)) begin : g_bad_dwell
            $error("muxn_scan: DWELL out of range for CNT_W");
        end
    endgenerate

    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;

    logic [SEL_W-1:0] w_nsel;
    logic [CNT_W-1:0] w_ncnt;
    logic [WIDTH-1:0] w_x_sel;
    logic             w_dwell_end;

    muxn_scan_sel #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_sel (
        .i_x   (x),
        .i_sel (r_sel),
        .o_y   (w_x_sel)
    );

    assign w_dwell_end = (r_cnt == DWELL_LAST);

    // Scan mode owns the select; a load strobe only matters in manual mode.
    always_comb begin
        w_nsel = r_sel;
        w_ncnt = '0;
        if (mode == MODE_SCAN) begin
            if (w_dwell_end) begin
                w_nsel = r_sel + SEL_W'(1);
            end
            w_ncnt = w_dwell_end ? '0 : r_cnt + CNT_W'(1);
        end else if (load) begin
            w_nsel = c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel     <= '0;
            r_cnt     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_sel     <= w_nsel;
            r_cnt     <= w_ncnt;
            r_y       <= w_x_sel;
            r_y_valid <= (w_nsel == r_sel);
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign ch      = r_sel;

endmodule

// File: tb/tb_muxn_scan.sv
// Bench for muxn_scan: reference model feeds an expected queue every cycle,
// plus directed checks of the documented scenarios.
module tb_muxn_scan;

    localparam int WIDTH = 8;
    localparam int SEL_W = 2;
    localparam int DWELL = 4;
    localparam int CNT_W = 16;
    localparam int NCH   = 2**SEL_W;

    logic                   clk;
    logic                   rst;
    logic [NCH*WIDTH-1:0]   x;
    logic [SEL_W-1:0]       c;
    logic                   load;
    logic                   mode;
    logic [WIDTH-1:0]       y;
    logic                   y_valid;
    logic [SEL_W-1:0]       ch;

    muxn_scan #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W),
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .c       (c),
        .load    (load),
        .mode    (mode),
        .y       (y),
        .y_valid (y_valid),
        .ch      (ch)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // expected entry: {ch, y_valid, y}
    logic [SEL_W+WIDTH:0] exp_q[$];

    // reference model state
    int m_sel = 0;
    int m_cnt = 0;
    logic [WIDTH-1:0] m_y = '0;
    logic m_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int nsel;
        int ncnt;
        if (rst) begin
            m_sel = 0;
            m_cnt = 0;
            m_y   = '0;
            m_v   = 1'b0;
        end else begin
            nsel = m_sel;
            ncnt = 0;
            if (mode) begin
                if (m_cnt == DWELL - 1) nsel = (m_sel + 1) % NCH;
                ncnt = (m_cnt == DWELL - 1) ? 0 : m_cnt + 1;
            end else if (load) begin
                nsel = int'(c);
            end
            m_y   = x[m_sel*WIDTH +: WIDTH];
            m_v   = (nsel == m_sel);
            m_sel = nsel;
            m_cnt = ncnt;
        end
        exp_q.push_back({SEL_W'(m_sel), m_v, m_y});
    endtask

    // One clock: predict, let the edge happen, compare off the edge.
    task automatic tick();
        logic [SEL_W+WIDTH:0] e;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_y",     32'(y),       32'(e[WIDTH-1:0]));
            check("sb_valid", 32'(y_valid), 32'(e[WIDTH]));
            check("sb_ch",    32'(ch),      32'(e[SEL_W+WIDTH:WIDTH+1]));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst  = 1'b1;
        x    = 32'($urandom);
        c    = SEL_W'($urandom_range(0, NCH - 1));
        load = 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1));

        // reset
        ticks(2);
        check("rst_y", 32'(y), 32'h0);
        check("rst_valid", 32'(y_valid), 32'h0);
        check("rst_ch", 32'(ch), 32'h0);

        rst  = 1'b0;
        mode = 1'b0;
        load = 1'b0;
        x    = {8'h44, 8'h33, 8'h22, 8'hA5};
        tick();
        check("rel_y", 32'(y), 32'hA5);
        check("rel_valid", 32'(y_valid), 32'h1);

        // manual load
        x = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        load = 1'b1;
        c    = 2'd2;
        tick();
        check("load_ch", 32'(ch), 32'h2);
        check("load_drop", 32'(y_valid), 32'h0);
        load = 1'b0;
        tick();
        check("load_y", 32'(y), 32'h33);
        check("load_valid", 32'(y_valid), 32'h1);
        load = 1'b1;
        tick();
        check("reload_same", 32'(y_valid), 32'h1);
        c = 2'd0;
        tick();
        load = 1'b0;
        tick();

        // scan wrap from channel 0
        mode = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k % 4 == 0) begin
                check("scan_ch", 32'(ch), 32'((k / 4) % 4));
                check("scan_drop", 32'(y_valid), 32'h0);
            end else if (k % 4 == 1 && k > 1) begin
                check("scan_y", 32'(y), 32'(8'h11 * (((k - 1) / 4) % 4 + 1)));
                check("scan_valid", 32'(y_valid), 32'h1);
            end
        end

        // load during scan is ignored (ch=1, cnt=0 here)
        tick();
        load = 1'b1;
        c    = 2'd3;
        tick();
        check("scan_load_ign", 32'(ch), 32'h1);
        load = 1'b0;
        ticks(2);
        check("scan_on_sched", 32'(ch), 32'h2);

        // load together with mode rising
        mode = 1'b0;
        tick();
        mode = 1'b1;
        load = 1'b1;
        c    = 2'd0;
        tick();
        check("mode_beats_load", 32'(ch), 32'h2);
        load = 1'b0;

        // mode switch at ch=2, cnt=2
        tick();
        mode = 1'b0;
        ticks(10);
        check("manual_hold", 32'(ch), 32'h2);
        mode = 1'b1;
        ticks(3);
        check("rescan_wait", 32'(ch), 32'h2);
        tick();
        check("rescan_adv", 32'(ch), 32'h3);

        // reset mid-scan at ch=1, cnt=3
        ticks(11);
        check("pre_rst_ch", 32'(ch), 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_ch", 32'(ch), 32'h0);
        check("mid_rst_y", 32'(y), 32'h0);
        check("mid_rst_valid", 32'(y_valid), 32'h0);
        rst  = 1'b0;
        mode = 1'b0;
        ticks(2);
        x[7:0] = 8'h5A;
        tick();
        check("live_y", 32'(y), 32'h5A);
        check("live_valid", 32'(y_valid), 32'h1);

        // random traffic against the model
        for (int i = 0; i < 60; i++) begin
            x    = 32'($urandom);
            c    = SEL_W'($urandom_range(0, NCH - 1));
            load = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            rst  = ($urandom_range(0, 29) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muxn_scan.md
Name: muxn_scan

Overview:
- Parametrised, registered N-to-1 multiplexer. WIDTH-bit channels, NCH = 2**SEL_W inputs.
- Two selection modes:
  - manual: the select is loaded via a strobe.
  - scan: the select auto-advances round-robin after a programmable dwell.
- Sits between multi-channel sources (counters, sensors, register banks) and a single downstream consumer or display path.
- Adds a valid flag marking when the output reflects the current channel.

Parameters:
- WIDTH, 8, bits per channel.
- SEL_W, 2, select width; NCH = 2**SEL_W channels.
- DWELL, 4, cycles per channel in scan mode; legal range 2..65535.
- CNT_W, 16, dwell counter width; must hold DWELL-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- x  in  NCH*WIDTH  packed channels; channel k = x[k*WIDTH +: WIDTH].
- c  in  SEL_W  manual select value.
- load  in  1  manual-mode strobe; captures c.
- mode  in  1  0 = manual, 1 = scan.
- y  out  WIDTH  registered selected channel.
- y_valid  out  1  y corresponds to ch.
- ch  out  SEL_W  current select register.

Behaviour:
- Internal state: sel (SEL_W), cnt (CNT_W), y, y_valid. ch = sel.
- Reset (rst=1 at a clk edge): sel=0, cnt=0, y=0, y_valid=0. Reset overrides every other input.
- Data path: every edge, y <= x[sel] using the pre-edge sel. Latency is 1 cycle from sel to y. Changes on x propagate to y in 1 cycle while sel is stable.
- Next-select rules, when rst=0:
  - mode=0 and load=1: nsel = c.
  - mode=0 and load=0: nsel = sel.
  - mode=1 and cnt==DWELL-1: nsel = sel+1, wrapping modulo NCH (NCH-1 -> 0).
  - mode=1 otherwise: nsel = sel.
- Valid: y_valid <= (nsel == sel).
  - A select change drops y_valid for exactly 1 cycle; it reasserts on the next edge if no further change.
  - load with c == sel causes no drop.
- Dwell counter:
  - mode=1: cnt <= (cnt==DWELL-1) ? 0 : cnt+1.
  - mode=0: cnt <= 0.
  - Each scanned channel is held for exactly DWELL cycles, of which DWELL-1 have y_valid=1.
- Mode transitions:
  - 0->1: scan starts from the held sel with cnt=0; the first advance occurs DWELL cycles later.
  - 1->0: sel is held; cnt clears.
- Simultaneous events:
  - load while mode=1 is ignored.
  - load and mode rising in the same cycle: mode wins and load is ignored.
  - rst mid-dwell or mid-scan: immediate return to reset values; scan resumes at channel 0 only if mode=1 after rst falls.
- No combinational path from inputs to outputs.

Decomposition:
- Shared constants header: MODE_MANUAL=1'b0, MODE_SCAN=1'b1, plus a legality check DWELL>=2 and DWELL<=2**CNT_W.
- One natural sub-module: muxn_sel. Purely combinational, parametrised WIDTH/SEL_W, slices x by sel.
- Sequencing (sel, cnt, valid) and the output register live in muxn_scan.

Test Plan:
- Reset: hold rst=1 for 2 cycles with arbitrary x/c/load/mode -> y=0, y_valid=0, ch=0. Release rst with mode=0 and x channel0=8'hA5 -> next cycle y=8'hA5, y_valid=1.
- Manual load: x={8'h44,8'h33,8'h22,8'h11}, pulse load with c=2 -> edge n: ch=2, y_valid=0; edge n+1: y=8'h33, y_valid=1. Pulse load again with c=2 -> y_valid stays 1.
- Scan wrap: mode=1 from ch=0, DWELL=4 -> ch sequence 0,1,2,3,0 with a change every 4 cycles. y_valid low exactly 1 cycle after each change. y tracks 8'h11, 22, 33, 44, 11.
- Load during scan: mode=1, pulse load with c=3 at cnt=1 -> ignored, ch advances on schedule. Load+mode rising in the same cycle -> sel unchanged.
- Mode switch: scan to ch=2 at cnt=2, drop mode -> ch holds at 2 indefinitely. Re-raise mode -> ch=3 after exactly 4 cycles.
- Reset mid-scan plus live data: rst=1 at cnt=3 on ch=1 -> ch=0, y=0, y_valid=0 next edge, no advance. Change x channel0 while stable -> y updates 1 cycle later, y_valid stays 1.
